// File: rtl/occ_pkg.sv
// Shared types and constants for the lot occupancy counter.
package occ_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        OCC_HOLD,
        OCC_INC,
        OCC_DEC
    } occ_op_e;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_updown_digit.sv
// One BCD digit of the ripple up/down chain. Purely combinational.
// cin_i means "this digit must step"; cout_o asks the next digit to step.
module bcd_updown_digit
    import occ_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  occ_op_e    op_i,
    input  logic       cin_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            case (op_i)
                OCC_INC: begin
                    if (digit_i == BCD_MAX) begin
                        digit_o = BCD_MIN;
                        cout_o  = 1'b1;
                    end else begin
                        digit_o = digit_i + 4'd1;
                    end
                end
                OCC_DEC: begin
                    if (digit_i == BCD_MIN) begin
                        digit_o = BCD_MAX;
                        cout_o  = 1'b1;
                    end else begin
                        digit_o = digit_i - 4'd1;
                    end
                end
                default: begin
                    digit_o = digit_i;
                    cout_o  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/occupancy_counter.sv
// Saturating occupancy counter with binary and BCD images kept in lockstep.
// Define OCC_PEAK_EN to add the peak-since-reset register and port.
module occupancy_counter
    import occ_pkg::*;
#(
    parameter int CAPACITY = 25,
    parameter int DIGITS   = 2,
    localparam int CW      = $clog2(CAPACITY + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enter,
    input  logic                  leave,
    output logic [CW-1:0]         count,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  full,
    output logic                  empty,
    output logic                  reject_in,
    output logic                  reject_out
`ifdef OCC_PEAK_EN
    ,
    output logic [CW-1:0]         peak
`endif
);

    localparam logic [CW-1:0] CAP_W = CW'(CAPACITY);

    if (CAPACITY < 1 || CAPACITY > 9999 || 10 ** DIGITS <= CAPACITY) begin : g_param_check
        $error("occupancy_counter: CAPACITY must be 1..9999 and below 10**DIGITS");
    end

    occ_op_e                      op;
    logic [CW-1:0]                count_q, count_d;
    logic [DIGITS-1:0][3:0]       bcd_q, bcd_d;
    logic                         full_q, full_d;
    logic                         empty_q, empty_d;
    logic                         reject_in_q, reject_in_d;
    logic                         reject_out_q, reject_out_d;
    logic [DIGITS:0]              chain;
    logic                         unused_top_carry;

    // Simultaneous enter and leave is a net-zero HOLD at every count.
    always_comb begin
        op           = OCC_HOLD;
        reject_in_d  = 1'b0;
        reject_out_d = 1'b0;
        if (enter && !leave) begin
            if (count_q == CAP_W) reject_in_d = 1'b1;
            else                  op = OCC_INC;
        end else if (leave && !enter) begin
            if (count_q == '0) reject_out_d = 1'b1;
            else               op = OCC_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        case (op)
            OCC_INC: count_d = count_q + CW'(1);
            OCC_DEC: count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CAP_W);
        empty_d = (count_d == '0);
    end

    assign chain[0] = (op != OCC_HOLD);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_updown_digit u_digit (
            .digit_i (bcd_q[i]),
            .op_i    (op),
            .cin_i   (chain[i]),
            .digit_o (bcd_d[i]),
            .cout_o  (chain[i+1])
        );
    end

    // Saturation guarantees the top digit never carries out.
    assign unused_top_carry = chain[DIGITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            bcd_q        <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            reject_in_q  <= 1'b0;
            reject_out_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            bcd_q        <= bcd_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            reject_in_q  <= reject_in_d;
            reject_out_q <= reject_out_d;
        end
    end

    assign count      = count_q;
    assign bcd        = bcd_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign reject_in  = reject_in_q;
    assign reject_out = reject_out_q;

`ifdef OCC_PEAK_EN
    logic [CW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (op == OCC_INC && count_d > peak_q) peak_d = count_d;
    end

    always_ff @(posedge clk) begin
        if (reset) peak_q <= '0;
        else       peak_q <= peak_d;
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// Randomised bench for occupancy_counter against an integer occupancy model.
// Build with OCC_PEAK_EN to exercise the peak register at CAPACITY=150, DIGITS=3.
module tb_occupancy_counter;

`ifdef OCC_PEAK_EN
    localparam int CAP = 150;
    localparam int DIG = 3;
`else
    localparam int CAP = 25;
    localparam int DIG = 2;
`endif
    localparam int CW = $clog2(CAP + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enter = 1'b0;
    logic              leave = 1'b0;
    logic [CW-1:0]     count;
    logic [4*DIG-1:0]  bcd;
    logic              full, empty, reject_in, reject_out;
`ifdef OCC_PEAK_EN
    logic [CW-1:0]     peak;
`endif

    int total = 0;
    int bad   = 0;

    // reference state
    int m_occ  = 0;
    int m_peak = 0;
    int m_rin  = 0;
    int m_rout = 0;

    always #5 clk = ~clk;

    occupancy_counter #(.CAPACITY(CAP), .DIGITS(DIG)) dut (
        .clk        (clk),
        .reset      (reset),
        .enter      (enter),
        .leave      (leave),
        .count      (count),
        .bcd        (bcd),
        .full       (full),
        .empty      (empty),
        .reject_in  (reject_in),
        .reject_out (reject_out)
`ifdef OCC_PEAK_EN
        ,
        .peak       (peak)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (occ=%0d)", tag, got, exp, m_occ);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check_all();
        chk("count", 32'(count), 32'(m_occ));
        chk("bcd", 32'(bcd), to_bcd(m_occ));
        chk("full", 32'(full), 32'(m_occ == CAP));
        chk("empty", 32'(empty), 32'(m_occ == 0));
        chk("reject_in", 32'(reject_in), 32'(m_rin));
        chk("reject_out", 32'(reject_out), 32'(m_rout));
`ifdef OCC_PEAK_EN
        chk("peak", 32'(peak), 32'(m_peak));
`endif
    endtask

    // Apply one cycle of requests, advance the model, check after the edge.
    task automatic cyc(input logic e, input logic l, input logic r);
        enter = e;
        leave = l;
        reset = r;
        @(posedge clk);
        if (r) begin
            m_occ = 0; m_peak = 0; m_rin = 0; m_rout = 0;
        end else begin
            m_rin  = (e && !l && m_occ == CAP) ? 1 : 0;
            m_rout = (l && !e && m_occ == 0) ? 1 : 0;
            if (e && !l && m_occ < CAP) m_occ++;
            else if (l && !e && m_occ > 0) m_occ--;
            if (m_occ > m_peak) m_peak = m_occ;
        end
        #1;
        check_all();
    endtask

    task automatic repeat_cyc(input int n, input logic e, input logic l);
        for (int k = 0; k < n; k++) cyc(e, l, 1'b0);
    endtask

    initial begin
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        repeat_cyc(3, 0, 0);

        // decimal carry then borrow across a digit boundary
        repeat_cyc(9, 1, 0);
        chk("bcd_9", 32'(bcd), 32'h09);
        cyc(1, 0, 0);
        chk("bcd_10", 32'(bcd), 32'h10);
        chk("count_10", 32'(count), 32'd10);
        cyc(0, 1, 0);
        chk("bcd_borrow", 32'(bcd), 32'h09);

        // fill past capacity: back-to-back rejects
        repeat_cyc(CAP + 5, 1, 0);
        chk("full_at_cap", 32'(full), 32'd1);
        chk("rin_held", 32'(reject_in), 32'd1);
        cyc(1, 1, 0);
        cyc(1, 1, 0);

        // drain, then refused exits and both-high at zero
        repeat_cyc(CAP, 0, 1);
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("rout_pulse", 32'(reject_out), 32'd1);
        cyc(0, 0, 0);
        chk("rout_clear", 32'(reject_out), 32'd0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);

        repeat_cyc(12, 1, 0);
        cyc(1, 1, 0);
        chk("both_12", 32'(count), 32'd12);
        repeat_cyc(5, 1, 0);
        cyc(1, 0, 1);
        chk("reset_prio", 32'(count), 32'd0);

        // peak scenario (saturates early at the default capacity)
        repeat_cyc(120, 1, 0);
        repeat_cyc(30, 0, 1);
        repeat_cyc(40, 1, 0);

        // random traffic with rare resets, biased to reach both ends
        for (int n = 0; n < 4000; n++) begin
            int bias = (n / 500) % 2;
            int p = $urandom_range(0, 99);
            logic e = (bias == 1) ? (p < 60) : (p < 30);
            logic l = ($urandom_range(0, 99) < ((bias == 1) ? 30 : 60));
            logic r = ($urandom_range(0, 299) == 0);
            cyc(e, l, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Parametrised saturating occupancy counter for the lot-monitor datapath. It tracks vehicles present from per-cycle entry/exit requests and keeps a binary count and a multi-digit BCD image in lockstep for the HEX display drivers. It also raises full/empty flags and single-cycle reject pulses for requests that cannot be honoured. It sits between the gate-sensor FSMs and the display/status logic.

## Interface
- CAPACITY, 25: maximum occupancy, 1..9999; count saturates here.
- DIGITS, 2: BCD digits on `bcd`; 10**DIGITS must exceed CAPACITY (elaboration-time assertion).
- CW (localparam), $clog2(CAPACITY+1): binary count width.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enter  in  1  entry request; each high cycle is one vehicle.
- leave  in  1  exit request; each high cycle is one vehicle.
- count  out  CW  binary occupancy.
- bcd  out  4*DIGITS  BCD occupancy, digit 0 in [3:0].
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- reject_in  out  1  entry refused (lot full).
- reject_out  out  1  exit refused (lot empty).
- peak  out  CW  maximum count since reset (only with OCC_PEAK_EN).

## Operation
- Per-cycle op is derived from enter, leave and the current count:
  - enter only, count < CAPACITY: INC.
  - enter only, count == CAPACITY: HOLD, reject_in.
  - leave only, count > 0: DEC.
  - leave only, count == 0: HOLD, reject_out.
  - Both high: HOLD, no reject, at every count including 0 and CAPACITY. Net zero; the counter never visits an intermediate value.
  - Neither high: HOLD.
- Levels are not edge-detected. A request held for k cycles is k events.
- BCD update is digit-serial ripple within one cycle:
  - INC: digit 9 becomes 0 and carries to the next digit.
  - DEC: digit 0 becomes 9 and borrows from the next digit.
  - Saturation means the top digit never wraps.
- Invariant: `bcd` is the decimal value of `count` at every cycle. The BCD image is never derived from the binary count by division.

## Timing
- All outputs are registered. Effects of requests sampled at edge N are visible after edge N.
- count, bcd, full and empty update together with no cross-cycle skew.
- reject_in and reject_out are high for exactly the one cycle following the offending request. Back-to-back refused requests give back-to-back pulses.
- Reset values: count 0, bcd 0, empty 1, full 0, reject_in 0, reject_out 0, peak 0.
- Reset has priority over enter and leave in the same cycle. Reset mid-stream returns all outputs to their reset values after that edge, with no residual pulses.

## Configuration
- OCC_PEAK_EN defined:
  - Adds port `peak` and a peak register.
  - peak updates to the new count on the same edge as an INC that exceeds it.
  - peak is cleared only by reset.
- OCC_PEAK_EN undefined: no `peak` port and no register. All other behaviour is identical.

## Structure
- Package `occ_pkg`:
  - `bcd_digit_t` (logic [3:0]).
  - `occ_op_e` enum {OCC_HOLD, OCC_INC, OCC_DEC}.
  - Constants BCD_MAX = 9, BCD_MIN = 0.
- Sub-module `bcd_updown_digit`:
  - Inputs: digit, op, carry/borrow in.
  - Outputs: next digit, carry/borrow out.
  - Combinational, instantiated DIGITS times in a generate chain.
- Top level holds the op decode, the binary register, the digit registers, the flag and reject registers, and the optional peak register.

## Test plan
- Reset, then idle 3 cycles: count 0, bcd 0x00, empty 1, full 0, rejects 0.
- 9 enter pulses, then 1 more: bcd 0x09 then 0x10, count 10. Then 1 leave: bcd 0x09 (borrow path).
- 25 enter pulses, then enter held 2 cycles: count 25, bcd 0x25, full 1, reject_in high for 2 consecutive cycles, count stays 25.
- Simultaneous enter+leave:
  - At count 25: count stays 25, no rejects.
  - At 0: count stays 0, no rejects.
  - At 12: count stays 12.
- Leave at count 0: reject_out high for 1 cycle, count 0, empty 1. Reset asserted at count 17 together with enter: count 0, bcd 0x00 next cycle.
- With OCC_PEAK_EN, CAPACITY=150, DIGITS=3: 120 enters then 30 leaves gives peak 120, count 90, bcd 0x090. Then 40 enters gives peak 130.
